proc_port_rr_scheduler: RTL
===========================

// Module: proc_port_rr_scheduler
// PURPOSE
//  Synchronous round-robin scheduler for a corner router's processor output port.
//  Shares the single proc output among four requesters: port1, port2, port3 and self-loopback.
//  Holds the winning flit in a 1-entry output register with a valid/ready handshake.
//  Keeps saturating per-requester grant counters for fairness and debug.
//  Sits between the input-side latches and the processor interface in clocked router builds.
// PARAMETERS
//  N        32  flit data width (bits)
//  CW       16  width of each per-requester grant counter
//  NREQ      4  number of requesters; fixed at 4 (router_pkg::NUM_PROC_REQ)
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   4       per-requester flit valid; [0]=port1 [1]=port2 [2]=port3 [3]=loopback
//  in_data    in   4*N     flattened flits; requester i occupies bits [i*N +: N]
//  in_ready   out  4       per-requester accept; one-hot or zero; combinational
//  out_valid  out  1       output register holds a flit
//  out_data   out  N       held flit
//  out_ready  in   1       processor accepts out_data this cycle
//  out_src    out  2       index of the requester whose flit is held
//  clr_stats  in   1       synchronous clear of all grant counters
//  grant_cnt  out  4*CW    saturating accept count per requester; requester i at [i*CW +: CW]
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, out_data=0, out_src=0, rr_ptr=0, all grant_cnt=0.
//   in_ready=0 while rst_n=0. A flit held at reset is discarded.
//  State: FSM EMPTY / FULL, encoded as out_valid.
//  can_load = EMPTY | (FULL & out_ready).
//  Winner: first i with in_valid[i], searching rr_ptr, rr_ptr+1, ... mod 4.
//  in_ready[winner] = can_load & |in_valid. All other in_ready bits = 0.
//  Accept (in_valid[w] & in_ready[w]) at a clock edge:
//   - out_data <= in_data[w]; out_src <= w; state -> FULL;
//   - rr_ptr <= (w+1) mod 4, 2-bit wrap;
//   - grant_cnt[w] += 1, saturating at 2^CW-1 (never wraps).
//  FULL & out_ready & no accept: state -> EMPTY; out_data and out_src keep their old values.
//  FULL & !out_ready: out_data and out_src are stable and out_valid stays 1 (no drop, no overwrite).
//  rr_ptr advances only on accept, never on idle cycles.
//  Latency: an input accepted at edge k is visible on out_* after edge k; zero bubble.
//  Throughput: 1 flit/cycle while out_ready=1.
//  Fairness: with all 4 requesters continuously valid, grants rotate strictly 0,1,2,3.
//  Any requester waits at most 3 other grants.
//  in_data is sampled only on accept. Dropping in_valid before accept is legal; nothing is recorded.
//  clr_stats=1 clears all counters. If an accept happens in the same cycle, that requester's counter ends at 1.
// STRUCTURE
//  router_pkg additions:
//   - typedef enum logic [1:0] {REQ_P1, REQ_P2, REQ_P3, REQ_LOOP} proc_req_t;
//   - localparam NUM_PROC_REQ = 4.
//  Sub-module rr_pick4 (combinational):
//   - inputs req[3:0], ptr[1:0]; outputs gnt_onehot[3:0], gnt_idx[1:0], any.
//   - reused by other output-port schedulers.
//  Top module: output register, FSM, rr_ptr, counter bank (generate loop).
// TESTING
//  T1 reset: rst_n=0 with in_valid=4'hF
//   -> in_ready=0, out_valid=0, grant_cnt all 0; after release, first grant goes to idx0.
//  T2 single: in_valid=4'b0100, data 0xA5A5_0003, out_ready=1
//   -> in_ready=4'b0100; next cycle out_valid=1, out_data=0xA5A5_0003, out_src=2, rr_ptr=3.
//  T3 contention: in_valid=4'hF held, out_ready=1
//   -> out_src sequence 0,1,2,3,0; one flit per cycle; each grant_cnt=2 after 8 cycles.
//  T4 backpressure: FULL with out_src=1, out_ready=0 for 5 cycles
//   -> out_data stable, in_ready=0; then out_ready=1 -> next winner accepted the same cycle.
//  T5 saturation: CW=3, requester 3 accepts 10 flits
//   -> grant_cnt[3]=7; then clr_stats+accept in same cycle -> grant_cnt[3]=1.
//  T6 mid-op reset: rst_n pulled low while FULL & !out_ready
//   -> out_valid=0 immediately (async); after release rr_ptr=0 and no stale flit is replayed.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions used by the output-port schedulers.
// Holds requester identifiers and the output-register state encoding.
package router_pkg;

  localparam int NUM_PROC_REQ = 4;

  typedef enum logic [1:0] {
    REQ_P1   = 2'd0,
    REQ_P2   = 2'd1,
    REQ_P3   = 2'd2,
    REQ_LOOP = 2'd3
  } proc_req_t;

  // The output-register state is its valid bit: EMPTY = 0, FULL = 1
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } port_state_t;

  function automatic logic [1:0] rr_after(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: returns the first request at or after ptr.
// Shared by every output-port scheduler in the router.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt_onehot,
  output logic [1:0] gnt_idx,
  output logic       any
);

  logic [1:0] idx;

  always_comb begin
    idx        = '0;
    gnt_idx    = ptr;
    gnt_onehot = '0;
    any        = |req;
    // Walk from the farthest offset inward so the nearest request to ptr wins
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        gnt_idx = idx;
      end
    end
    if (any) begin
      gnt_onehot = 4'b0001 << gnt_idx;
    end
  end

endmodule

// File: rtl/proc_port_rr_scheduler.sv
// Round-robin scheduler for the processor output port: four requesters share one
// registered output slot with valid/ready handshake and saturating grant counters.
module proc_port_rr_scheduler
  import router_pkg::*;
#(
  parameter int N    = 32,
  parameter int CW   = 16,
  parameter int NREQ = NUM_PROC_REQ
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      in_valid,
  input  logic [NREQ*N-1:0]    in_data,
  output logic [NREQ-1:0]      in_ready,
  output logic                 out_valid,
  output logic [N-1:0]         out_data,
  input  logic                 out_ready,
  output logic [1:0]           out_src,
  input  logic                 clr_stats,
  output logic [NREQ*CW-1:0]   grant_cnt
);

  port_state_t state_q, state_d;
  logic [N-1:0] data_q, data_d;
  proc_req_t    src_q, src_d;
  logic [1:0]   rr_ptr_q, rr_ptr_d;

  logic [3:0] win_onehot;
  logic [1:0] win_idx;
  logic       win_any;
  logic       can_load;
  logic       accept;

  rr_pick4 u_pick (
    .req        (in_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (win_onehot),
    .gnt_idx    (win_idx),
    .any        (win_any)
  );

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

  // A slot opens either when empty or when the held flit leaves this cycle
  assign can_load = !out_valid || out_ready;
  assign in_ready = (rst_n && can_load && win_any) ? win_onehot : '0;
  assign accept   = |(in_valid & in_ready);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      state_d  = ST_FULL;
      data_d   = in_data[win_idx*N +: N];
      src_d    = proc_req_t'(win_idx);
      rr_ptr_d = rr_after(win_idx);
    end else if (out_valid && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      data_q   <= '0;
      src_q    <= REQ_P1;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Clear takes effect first, so a same-cycle accept lands on a zeroed counter
  for (genvar i = 0; i < NREQ; i++) begin : g_cnt
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = clr_stats ? '0 : cnt_q;
      if (accept && (win_idx == 2'(i))) begin
        cnt_d = sat_inc(cnt_d);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_cnt[i*CW +: CW] = cnt_q;
  end

endmodule
